alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the 32-bit ALU.
- Accepts decoded instruction fields plus register-file read values, and maps opcode/funct to the ALU's 3-bit op code.
- Selects operand b as register or extended immediate, applies single-source result forwarding, and presents a/b/op to the ALU.
- Outputs come from a 2-entry valid/ready skid buffer, so a downstream stall never creates a combinational path back to the producer.

Parameters:
WIDTH, 32, datapath width of the a/b operands and forwarded value; immediate extension fills bits [WIDTH-1:16].

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept this cycle
in_opcode  input  6  instruction opcode field
in_funct  input  6  funct field, used only when opcode=0
in_rs_idx  input  5  rs register index
in_rt_idx  input  5  rt register index
in_wr_idx  input  5  destination register index, passed through
in_rs_val  input  WIDTH  register-file value of rs
in_rt_val  input  WIDTH  register-file value of rt
in_imm  input  16  immediate field
fwd_valid  input  1  forwarded result is valid
fwd_idx  input  5  destination index of the forwarded result
fwd_val  input  WIDTH  forwarded result value
out_valid  output  1  head entry valid
out_ready  input  1  ALU side consumes the head entry
out_a  output  WIDTH  ALU operand a
out_b  output  WIDTH  ALU operand b
out_op  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
out_wr_idx  output  5  passed-through destination index
out_illegal  output  1  undecodable instruction flag

Behaviour:
- Reset (async, active-high), while rst=1:
  - state=EMPTY, out_valid=0, in_ready=0.
  - out_a, out_b, out_op, out_wr_idx, out_illegal, and the skid entry are all 0.
  - in_ready rises on the first clock edge after rst deasserts.
  - Reset mid-transfer discards both entries; no partial state survives.
- Decode (combinational, applied at capture):
  - opcode 0x00 with funct 0x24/0x25/0x20/0x22/0x2A gives op 000/001/010/110/111, b=rt.
  - 0x08 addi: 010, b=signext(imm).
  - 0x0C andi: 000, b=zeroext(imm).
  - 0x0D ori: 001, b=zeroext(imm).
  - 0x0A slti: 111, b=signext(imm).
  - 0x23 lw and 0x2B sw: 010, b=signext(imm).
  - 0x04 beq: 110, b=rt.
  - Any other opcode/funct: op 010, b=rt, out_illegal=1; the entry still flows normally.
- Operand source, for rs and rt independently:
  - idx=0 gives 0.
  - Else fwd_valid && fwd_idx==idx gives fwd_val.
  - Else the register-file value.
  - Forwarding is sampled only in the accept cycle. An entry held in the skid or head is never re-forwarded; hazards beyond one cycle belong to upstream.
- Handshake:
  - accept = in_valid && in_ready; pop = out_valid && out_ready.
  - in_ready = (state != TWO) && !rst, driven from state flops only.
  - out_valid = (state != EMPTY).
  - Output fields hold stable while out_valid=1 and out_ready=0.
- States and transitions:
  - EMPTY: accept loads head, go to ONE.
  - ONE, accept && pop: head reloads from input, stay ONE.
  - ONE, accept && !pop: input goes to skid, go to TWO.
  - ONE, pop && !accept: go to EMPTY.
  - ONE, neither: hold.
  - TWO: no accept is possible. Pop moves skid to head, go to ONE; otherwise hold.
- Latency:
  - Accept in cycle N gives out_valid in N+1 when the buffer was EMPTY, or when it was ONE with a pop in N.
  - Throughput is 1 per cycle with out_ready held high.
- Ordering is strict FIFO; no entry is dropped or duplicated.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> out_valid=0, all outputs 0, in_ready=0 during rst and 1 one edge after release.
- Decode sweep, out_ready=1: addi rs=3 (val 5) imm=0xFFFF -> out_a=5, out_b=0xFFFFFFFF, op=010; ori imm=0x8000 -> out_b=0x00008000, op=001; slt funct 0x2A -> op=111; opcode 0x3F -> out_illegal=1, op=010.
- Forwarding: in_rs_idx=7, in_rs_val=1, fwd_valid=1, fwd_idx=7, fwd_val=0xDEADBEEF -> out_a=0xDEADBEEF. Same with in_rs_idx=0 -> out_a=0. Forwarding asserted one cycle after accept -> no effect.
- Stall fill: out_ready=0, issue A, B, C back-to-back -> A and B accepted, in_ready=0 from the cycle after B, C held. out_ready=1 -> A, then B, then C in order, no gaps once ready.
- Simultaneous accept and pop in ONE: stream 100 instructions with out_ready=1 -> 100 outputs in order, in_ready never drops.
- Reset with state TWO: assert rst -> out_valid=0 asynchronously. After release, the first new entry appears with no stale data.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the 32-bit ALU: decodes opcode/funct, selects and
// forwards operands, and presents them through a 2-entry valid/ready skid buffer.
module alu_issue_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [5:0]       in_funct,
    input  logic [4:0]       in_rs_idx,
    input  logic [4:0]       in_rt_idx,
    input  logic [4:0]       in_wr_idx,
    input  logic [WIDTH-1:0] in_rs_val,
    input  logic [WIDTH-1:0] in_rt_val,
    input  logic [15:0]      in_imm,
    input  logic             fwd_valid,
    input  logic [4:0]       fwd_idx,
    input  logic [WIDTH-1:0] fwd_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [2:0]       out_op,
    output logic [4:0]       out_wr_idx,
    output logic             out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic [4:0]       wr;
        logic             ill;
    } entry_t;

    state_t     r_state;
    logic       r_rdy_en;
    entry_t     r_head;
    entry_t     r_skid;

    logic       w_accept;
    logic       w_pop;
    logic [2:0] w_op;
    logic       w_use_imm;
    logic       w_sext;
    logic       w_ill;
    logic [WIDTH-1:0] w_imm_ext;
    logic [WIDTH-1:0] w_rs_src;
    logic [WIDTH-1:0] w_rt_src;
    entry_t     w_new;

    // Register zero reads as 0; a matching forwarded result beats the register file.
    function automatic logic [WIDTH-1:0] fn_src(
        input logic [4:0]       idx,
        input logic [WIDTH-1:0] rf_val,
        input logic             f_vld,
        input logic [4:0]       f_idx,
        input logic [WIDTH-1:0] f_val
    );
        if (idx == 5'd0)
            return '0;
        else if (f_vld && (f_idx == idx))
            return f_val;
        else
            return rf_val;
    endfunction

    always_comb begin
        w_op      = 3'b010;
        w_use_imm = 1'b0;
        w_sext    = 1'b0;
        w_ill     = 1'b0;
        case (in_opcode)
            6'h00: begin
                case (in_funct)
                    6'h24:   w_op = 3'b000;
                    6'h25:   w_op = 3'b001;
                    6'h20:   w_op = 3'b010;
                    6'h22:   w_op = 3'b110;
                    6'h2A:   w_op = 3'b111;
                    default: w_ill = 1'b1;
                endcase
            end
            6'h08, 6'h23, 6'h2B: begin
                w_op      = 3'b010;
                w_use_imm = 1'b1;
                w_sext    = 1'b1;
            end
            6'h0C: begin
                w_op      = 3'b000;
                w_use_imm = 1'b1;
            end
            6'h0D: begin
                w_op      = 3'b001;
                w_use_imm = 1'b1;
            end
            6'h0A: begin
                w_op      = 3'b111;
                w_use_imm = 1'b1;
                w_sext    = 1'b1;
            end
            6'h04:   w_op  = 3'b110;
            default: w_ill = 1'b1;
        endcase
    end

    assign w_imm_ext = w_sext ? {{(WIDTH-16){in_imm[15]}}, in_imm}
                              : {{(WIDTH-16){1'b0}}, in_imm};
    assign w_rs_src  = fn_src(in_rs_idx, in_rs_val, fwd_valid, fwd_idx, fwd_val);
    assign w_rt_src  = fn_src(in_rt_idx, in_rt_val, fwd_valid, fwd_idx, fwd_val);

    always_comb begin
        w_new     = '0;
        w_new.a   = w_rs_src;
        w_new.b   = w_use_imm ? w_imm_ext : w_rt_src;
        w_new.op  = w_op;
        w_new.wr  = in_wr_idx;
        w_new.ill = w_ill;
    end

    // Ready depends only on flops (and reset), so out_ready never reaches in_ready.
    assign in_ready  = r_rdy_en && (r_state != TWO) && !rst;
    assign out_valid = (r_state != EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_a       = r_head.a;
    assign out_b       = r_head.b;
    assign out_op      = r_head.op;
    assign out_wr_idx  = r_head.wr;
    assign out_illegal = r_head.ill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_rdy_en <= 1'b0;
            r_head   <= '0;
            r_skid   <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_head  <= w_new;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_new;
                    end else if (w_accept) begin
                        r_skid  <= w_new;
                        r_state <= TWO;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        r_head  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule
